seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter N, default 4: LFSR width, legal 2..8.
REQ-002 SHALL have parameter LOCK_CNT, default 3: consecutive matches needed to lock, legal 1..15.
REQ-003 SHALL have parameter LOSS_CNT, default 2: consecutive mismatches that drop lock, legal 1..15.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear to IDLE; also zeroes err_count.
REQ-007 valid  in  1  one-cycle strobe; seq_in holds a new sample.
REQ-008 seq_in  in  8  received sequence word; bits [N-1:0] used, upper bits ignored.
REQ-009 char_polynomial  in  N  tap mask, same encoding as the generator.
REQ-010 locked  out  1  high while in LOCKED.
REQ-011 err_pulse  out  1  one-cycle pulse per mismatch while LOCKED.
REQ-012 err_count  out  8  saturating mismatch count.
REQ-013 expected  out  8  predicted next sample, zero-extended.
REQ-014 zero_trap  out  1  one-cycle pulse on rejected all-zero seed.

Function
REQ-015 LFSR step SHALL be next(s) = {s[N-2:0], XOR-reduce(s & char_polynomial)}.
REQ-016 Register prev (N bits) SHALL hold the last reference value; expected SHALL equal next(prev), combinational from the register.
REQ-017 FSM states SHALL be IDLE, SEEK, LOCKED; nothing happens on cycles with valid=0.
REQ-018 IDLE + valid: prev <= sample; match_cnt <= 0; go to SEEK.
REQ-019 SEEK + valid: on match, match_cnt increments and reaching LOCK_CNT goes to LOCKED with miss_cnt <= 0; on mismatch, match_cnt <= 0; prev <= sample in both cases. err_count SHALL be unaffected.
REQ-020 LOCKED + valid: prev <= expected (flywheel, sample not used for reseed); on match, miss_cnt <= 0; on mismatch, err_pulse fires the next cycle, err_count increments saturating at 255, and miss_cnt increments; reaching LOSS_CNT goes to SEEK with match_cnt <= 0 and prev <= sample.
REQ-021 locked, err_pulse and zero_trap SHALL be registered, asserting the cycle after the triggering valid.
REQ-022 clr together with valid: clr wins and the sample is discarded.
REQ-023 char_polynomial SHALL be sampled combinationally each cycle; changing it mid-stream simply causes mismatches, with no special handling.

Reset
REQ-024 On rst low, all of the following SHALL clear asynchronously: state to IDLE, prev, match_cnt, miss_cnt and err_count to 0, and locked, err_pulse and zero_trap to 0.
REQ-025 expected SHALL read next(0) = 0 during and after reset.

Configuration
REQ-026 With SEQ_CHECKER_ZERO_TRAP_EN defined: an all-zero sample in IDLE or as a SEEK reseed SHALL be rejected, force IDLE and pulse zero_trap, because an all-zero sample is the LFSR lockup state.
REQ-027 Without the macro, zero SHALL be treated as an ordinary sample, and zero_trap SHALL be tied 0 with the port still present.

Structure
REQ-028 Package seq_checker_pkg SHALL hold the state enum (IDLE=0, SEEK=1, LOCKED=2), the 8-bit err_count width constant and its saturation value 255.
REQ-029 Sub-module lfsr_next_state (purely combinational; parameter N; inputs s and poly; output next) SHALL implement REQ-015 and be reusable by the generator.

Verification (N=4, char_polynomial=4'b1001; reference sequence 1,3,7,15,14,13)
REQ-030 Reset, then samples 1,3,7,15 -> locked=1 the cycle after the 15; expected=14.
REQ-031 Locked, then sample 5 in place of 14 -> err_pulse once, err_count=1, locked stays 1; then sample 13 -> match, no pulse.
REQ-032 Locked, then samples 5 and 5 -> err_count=2 and locked=0 after the second; state SEEK with prev=5.
REQ-033 Locked, then 300 bad samples with LOSS_CNT=15 and repeated relock -> err_count holds at 255.
REQ-034 Macro on, sample 0 in IDLE -> zero_trap pulse and state stays IDLE; macro off -> SEEK with expected=0.
REQ-035 clr and valid in the same cycle while locked with err_count=3 -> IDLE, err_count=0, locked=0.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the sequence checker.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned               ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0]      ERR_CNT_SAT = 8'd255;

endpackage

// File: rtl/seq_checker_if.sv
// Sample-stream and status bundle between a sequence source and seq_checker.
interface seq_checker_if #(
    parameter int unsigned N = 4
);
    import seq_checker_pkg::*;

    logic                 valid;
    logic [7:0]           seq_in;
    logic [N-1:0]         char_polynomial;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [7:0]           expected;
    logic                 zero_trap;

    modport master (
        output valid, seq_in, char_polynomial,
        input  locked, err_pulse, err_count, expected, zero_trap
    );

    modport slave (
        input  valid, seq_in, char_polynomial,
        output locked, err_pulse, err_count, expected, zero_trap
    );

endinterface

// File: rtl/seq_checker_lfsr.sv
// One Fibonacci LFSR step; shared by the checker and the matching generator.
module lfsr_next_state #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] s,
    input  logic [N-1:0] poly,
    output logic [N-1:0] next
);

    assign next = {s[N-2:0], ^(s & poly)};

endmodule

// File: rtl/seq_checker.sv
// LFSR sequence checker: seeks, locks and flywheels on a received PRBS stream.
// Optional zero-seed rejection is enabled by defining SEQ_CHECKER_ZERO_TRAP_EN.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    seq_checker_if.slave  bus
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    state_e               state_q, state_d;
    logic [N-1:0]         prev_q, prev_d;
    logic [3:0]           match_cnt_q, match_cnt_d;
    logic [3:0]           miss_cnt_q, miss_cnt_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 locked_q, err_pulse_q, err_pulse_d;

    logic [N-1:0] sample, poly, exp_n;
    logic [3:0]   match_inc, miss_inc;
    logic         match, zero_reject;
    logic         unused_hi;

    assign sample    = bus.seq_in[N-1:0];
    assign poly      = bus.char_polynomial;
    assign unused_hi = ^(bus.seq_in >> N);
    assign match     = (sample == exp_n);
    assign match_inc = match_cnt_q + 4'd1;
    assign miss_inc  = miss_cnt_q + 4'd1;

    lfsr_next_state #(.N(N)) u_next (
        .s    (prev_q),
        .poly (poly),
        .next (exp_n)
    );

`ifdef SEQ_CHECKER_ZERO_TRAP_EN
    logic zero_trap_q, zero_trap_d;

    assign zero_reject = (sample == '0);
    assign zero_trap_d = bus.valid & ~clr & zero_reject
                       & ((state_q == IDLE) | (state_q == SEEK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) zero_trap_q <= 1'b0;
        else      zero_trap_q <= zero_trap_d;
    end

    assign bus.zero_trap = zero_trap_q;
`else
    assign zero_reject   = 1'b0;
    assign bus.zero_trap = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (clr) begin
            state_d     = IDLE;
            prev_d      = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            err_count_d = '0;
        end else if (bus.valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!zero_reject) begin
                        prev_d      = sample;
                        match_cnt_d = '0;
                        state_d     = SEEK;
                    end
                end
                SEEK: begin
                    if (zero_reject) begin
                        state_d     = IDLE;
                        prev_d      = '0;
                        match_cnt_d = '0;
                    end else begin
                        prev_d = sample;
                        if (match) begin
                            match_cnt_d = match_inc;
                            if (match_inc == LOCK_C) begin
                                state_d    = LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the local LFSR keeps running; the sample only reseeds on loss.
                    prev_d = exp_n;
                    if (match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != ERR_CNT_SAT) err_count_d = err_count_q + 8'd1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == LOSS_C) begin
                            state_d     = SEEK;
                            match_cnt_d = '0;
                            prev_d      = sample;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_count_q <= err_count_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.expected  = 8'(exp_n);

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker (N=4, polynomial 4'b1001: 1,3,7,15,14,13,10,...).
module tb_seq_checker;

`ifdef SEQ_CHECKER_ZERO_TRAP_EN
    localparam bit ZT = 1'b1;
`else
    localparam bit ZT = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       clr;
        logic       valid;
        logic [7:0] seq;
        logic       locked;
        logic       pulse;
        logic [7:0] cnt;
        logic [7:0] expv;
        logic       trap;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clr   = 1'b0;
    logic clr_s = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    seq_checker_if #(.N(4)) bus   ();
    seq_checker_if #(.N(4)) bus_s ();

    seq_checker #(.N(4), .LOCK_CNT(3), .LOSS_CNT(2)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    seq_checker #(.N(4), .LOCK_CNT(3), .LOSS_CNT(15)) dut_sat (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .bus (bus_s)
    );

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    function automatic vec_t mk(input string nm, input logic c, input logic v,
                                input logic [7:0] s, input logic l, input logic p,
                                input logic [7:0] cnt, input logic [7:0] ex, input logic t);
        vec_t r;
        r.name = nm; r.clr = c; r.valid = v; r.seq = s;
        r.locked = l; r.pulse = p; r.cnt = cnt; r.expv = ex; r.trap = t;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        clr          = v.clr;
        bus.valid    = v.valid;
        bus.seq_in   = v.seq;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".locked"},    32'(bus.locked),    32'(e.locked));
        check({e.name, ".err_pulse"}, 32'(bus.err_pulse), 32'(e.pulse));
        check({e.name, ".err_count"}, 32'(bus.err_count), 32'(e.cnt));
        check({e.name, ".expected"},  32'(bus.expected),  32'(e.expv));
        check({e.name, ".zero_trap"}, 32'(bus.zero_trap), 32'(e.trap));
    endtask

    task automatic drive_s(input logic [3:0] v);
        @(negedge clk);
        bus_s.valid  = 1'b1;
        bus_s.seq_in = {4'h0, v};
        @(posedge clk);
        #1;
        bus_s.valid  = 1'b0;
    endtask

    initial begin
        logic [3:0] r, e, b;
        int bad, miss;

        bus.valid = 1'b0;   bus.seq_in = '0;   bus.char_polynomial = 4'b1001;
        bus_s.valid = 1'b0; bus_s.seq_in = '0; bus_s.char_polynomial = 4'b1001;

        //            name        clr  vld  seq    lock  pulse cnt  exp  trap
        tbl.push_back(mk("seed_hi",    0, 1, 8'hA1, 0,   0,    0,   3,   0));
        tbl.push_back(mk("gap0",       0, 0, 8'h09, 0,   0,    0,   3,   0));
        tbl.push_back(mk("seek_m1",    0, 1, 8'h03, 0,   0,    0,   7,   0));
        tbl.push_back(mk("seek_m2",    0, 1, 8'h07, 0,   0,    0,   15,  0));
        tbl.push_back(mk("lock_a",     0, 1, 8'h0F, 1,   0,    0,   14,  0));
        tbl.push_back(mk("miss1",      0, 1, 8'h05, 1,   1,    1,   13,  0));
        tbl.push_back(mk("recover",    0, 1, 8'h0D, 1,   0,    1,   10,  0));
        tbl.push_back(mk("miss_a",     0, 1, 8'h02, 1,   1,    2,   5,   0));
        tbl.push_back(mk("loss_a",     0, 1, 8'h02, 0,   1,    3,   4,   0));
        tbl.push_back(mk("reseek",     0, 1, 8'h01, 0,   0,    3,   3,   0));
        tbl.push_back(mk("reseek_m1",  0, 1, 8'h03, 0,   0,    3,   7,   0));
        tbl.push_back(mk("reseek_m2",  0, 1, 8'h07, 0,   0,    3,   15,  0));
        tbl.push_back(mk("lock_b",     0, 1, 8'h0F, 1,   0,    3,   14,  0));
        tbl.push_back(mk("miss_b",     0, 1, 8'h05, 1,   1,    4,   13,  0));
        tbl.push_back(mk("loss_b",     0, 1, 8'h05, 0,   1,    5,   11,  0));
        tbl.push_back(mk("gap1",       0, 0, 8'h00, 0,   0,    5,   11,  0));
        tbl.push_back(mk("seek_c1",    0, 1, 8'h0B, 0,   0,    5,   6,   0));
        tbl.push_back(mk("seek_c2",    0, 1, 8'h06, 0,   0,    5,   12,  0));
        tbl.push_back(mk("lock_c",     0, 1, 8'h0C, 1,   0,    5,   9,   0));
        tbl.push_back(mk("miss_c",     0, 1, 8'h03, 1,   1,    6,   2,   0));
        tbl.push_back(mk("clr_valid",  1, 1, 8'h02, 0,   0,    0,   0,   0));
        tbl.push_back(mk("after_clr",  0, 1, 8'h07, 0,   0,    0,   15,  0));
        tbl.push_back(mk("clr_only",   1, 0, 8'h00, 0,   0,    0,   0,   0));
        tbl.push_back(mk("zero_idle",  0, 1, 8'h00, 0,   0,    0,   0,   ZT));
        tbl.push_back(mk("zero_2",     0, 1, 8'h00, 0,   0,    0,   0,   ZT));
        tbl.push_back(mk("zero_3",     0, 1, 8'h00, 0,   0,    0,   0,   ZT));
        tbl.push_back(mk("zero_4",     0, 1, 8'h00, !ZT, 0,    0,   0,   ZT));
        tbl.push_back(mk("clr2",       1, 0, 8'h00, 0,   0,    0,   0,   0));
        tbl.push_back(mk("seed1",      0, 1, 8'h01, 0,   0,    0,   3,   0));
        tbl.push_back(mk("zero_seek",  0, 1, 8'h00, 0,   0,    0,   0,   ZT));

        #2 rst = 1'b0;
        #1;
        check("rst.locked",    32'(bus.locked),      32'd0);
        check("rst.err_pulse", 32'(bus.err_pulse),   32'd0);
        check("rst.err_count", 32'(bus.err_count),   32'd0);
        check("rst.expected",  32'(bus.expected),    32'd0);
        check("rst.zero_trap", 32'(bus.zero_trap),   32'd0);
        check("rst.sat_count", 32'(bus_s.err_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("post_rst.expected", 32'(bus.expected), 32'd0);

        foreach (tbl[i]) apply(tbl[i]);
        @(negedge clk);
        clr       = 1'b0;
        bus.valid = 1'b0;

        // Saturation: lock, then 20 rounds of 15 mismatches (loses lock) plus a 3-sample relock.
        drive_s(4'd1); drive_s(4'd3); drive_s(4'd7); drive_s(4'd15);
        check("sat.lock", 32'(bus_s.locked), 32'd1);
        r   = 4'd15;
        bad = 0;
        while (bad < 300) begin
            miss = 0;
            while (miss < 15 && bad < 300) begin
                e = nxt(r);
                b = e ^ 4'h1;
                if (b == 4'h0) b = e ^ 4'h3;
                drive_s(b);
                bad++;
                miss++;
                r = (miss == 15) ? b : e;
                if (bad == 14)  check("sat.hold_lock_14", 32'(bus_s.locked),    32'd1);
                if (bad == 15)  check("sat.drop_lock_15", 32'(bus_s.locked),    32'd0);
                if (bad == 254) check("sat.count_254",    32'(bus_s.err_count), 32'd254);
                if (bad == 255) check("sat.count_255",    32'(bus_s.err_count), 32'd255);
                if (bad == 300) check("sat.pulse_300",    32'(bus_s.err_pulse), 32'd1);
            end
            if (miss == 15) begin
                for (int k = 0; k < 3; k++) begin
                    r = nxt(r);
                    drive_s(r);
                end
            end
        end
        check("sat.relocked",    32'(bus_s.locked),    32'd1);
        check("sat.count_final", 32'(bus_s.err_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
